// File: rtl/program_memory.sv
// program_memory
//   Small program/data memory with two write paths: a CPU bus and a program loader.
//   The CPU side latches an address (iaen), then writes through it (iden). odata always
//   shows mem[CPU address].
//   The loader side is a two-state FSM (RUN/LOAD). While it is in LOAD, loader beats
//   fill the memory sequentially from address 0.
//   oload_busy is the FSM state. It is high exactly when the FSM is in LOAD.
//
// Handshake: a loader beat transfers on a rising edge where ild_valid && old_ready.
//   old_ready is driven only from the FSM state, so it never depends on ild_valid.
//   ild_last is meaningful only on a beat that transfers.
//
// Ports
//   iclk, irst_n          clock, asynchronous active-low reset
//   iaen, iden, idata     CPU address latch enable, CPU write enable, CPU bus data
//   odata                 read data = mem[CPU address]
//   iload_req             enter LOAD (ignored while already loading)
//   ild_valid/data/last   loader beat stream
//   old_ready             loader may transfer this cycle
//   oload_busy            high while in LOAD
//   oload_done            one-cycle pulse after the terminating beat
//   oload_count           words written by the current or most recent load
module program_memory #(
  parameter int pDATA_WIDTH   = 8,
  parameter int pADDR_WIDTH   = 4,
  parameter int pREAD_LATENCY = 0
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   iaen,
  input  logic                   iden,
  input  logic [pDATA_WIDTH-1:0] idata,
  output logic [pDATA_WIDTH-1:0] odata,
  input  logic                   iload_req,
  input  logic                   ild_valid,
  input  logic [pDATA_WIDTH-1:0] ild_data,
  input  logic                   ild_last,
  output logic                   old_ready,
  output logic                   oload_busy,
  output logic                   oload_done,
  output logic [pADDR_WIDTH:0]   oload_count
);

  localparam int pMEM_DEPTH = 2 ** pADDR_WIDTH;

  // Elaboration-time parameter guards.
  if (pADDR_WIDTH > pDATA_WIDTH) begin : g_bad_addr_width
    $error("program_memory: pADDR_WIDTH must not exceed pDATA_WIDTH");
  end
  if (pREAD_LATENCY != 0 && pREAD_LATENCY != 1) begin : g_bad_latency
    $error("program_memory: pREAD_LATENCY must be 0 or 1");
  end

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [pDATA_WIDTH-1:0] mem [pMEM_DEPTH];
  logic [pADDR_WIDTH-1:0] cpu_addr;
  logic [pADDR_WIDTH-1:0] ld_ptr;
  logic [pADDR_WIDTH:0]   ld_count;
  logic                   done_q;

  logic start_load;
  logic beat_acc;
  logic beat_term;
  logic cpu_we;
  logic addr_we;

  // CPU-side controls and load start are qualified with RUN.
  // This keeps the CPU side from doing anything during LOAD.
  assign start_load = (state_q == ST_RUN) && iload_req;
  assign cpu_we     = (state_q == ST_RUN) && iden;
  assign addr_we    = (state_q == ST_RUN) && iaen;
  assign beat_acc   = ild_valid && old_ready;

  // A load ends on an explicit last beat, or when the top word is written.
  // The pointer therefore never wraps back over word 0.
  assign beat_term  = beat_acc && (ild_last || (ld_ptr == {pADDR_WIDTH{1'b1}}));

  // FSM state register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and state-derived outputs
  always_comb begin
    state_d    = state_q;
    old_ready  = 1'b0;
    oload_busy = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (iload_req) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        old_ready  = 1'b1;
        oload_busy = 1'b1;
        if (beat_term) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Load pointer and word count. Both clear on the edge that enters LOAD.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ld_ptr   <= '0;
      ld_count <= '0;
    end else if (start_load) begin
      ld_ptr   <= '0;
      ld_count <= '0;
    end else if (beat_acc) begin
      ld_count <= ld_count + 1'b1;
      if (ld_ptr != {pADDR_WIDTH{1'b1}}) ld_ptr <= ld_ptr + 1'b1;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= beat_term;
    end
  end

  // CPU address register. On an edge where iaen and iden are both high, the write
  // uses the address held before that edge.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cpu_addr <= '0;
    end else if (addr_we) begin
      cpu_addr <= idata[pADDR_WIDTH-1:0];
    end
  end

  // Memory array.
  // Loader writes happen only in LOAD, and CPU writes only in RUN, so the two
  // write paths never collide.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < pMEM_DEPTH; i++) mem[i] <= '0;
    end else if (beat_acc) begin
      mem[ld_ptr] <= ild_data;
    end else if (cpu_we) begin
      mem[cpu_addr] <= idata;
    end
  end

  if (pREAD_LATENCY == 0) begin : g_read_comb
    assign odata = mem[cpu_addr];
  end else begin : g_read_reg
    logic [pDATA_WIDTH-1:0] rd_q;
    always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= mem[cpu_addr];
      end
    end
    assign odata = rd_q;
  end

  assign oload_done  = done_q;
  assign oload_count = ld_count;

endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory
//   Self-checking bench for program_memory with the default parameters
//   (8-bit data, 16 words, combinational read).
//   Directed scenarios and a randomized run are both checked against a
//   behavioural model kept in this file.
module tb_program_memory;

  logic       iclk = 1'b0;
  logic       irst_n;
  logic       iaen, iden, iload_req, ild_valid, ild_last;
  logic [7:0] idata, ild_data, odata;
  logic       old_ready, oload_busy, oload_done;
  logic [4:0] oload_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural reference model.
  // The word count doubles as the next load address, since loads always start at 0.
  logic [7:0] m_mem [16];
  logic [3:0] m_addr;
  bit         m_load;
  bit         m_done;
  int         m_count;

  program_memory dut (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .iaen        (iaen),
    .iden        (iden),
    .idata       (idata),
    .odata       (odata),
    .iload_req   (iload_req),
    .ild_valid   (ild_valid),
    .ild_data    (ild_data),
    .ild_last    (ild_last),
    .old_ready   (old_ready),
    .oload_busy  (oload_busy),
    .oload_done  (oload_done),
    .oload_count (oload_count)
  );

  always #5 iclk = ~iclk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_addr  = 4'h0;
    m_load  = 1'b0;
    m_done  = 1'b0;
    m_count = 0;
  endtask

  task automatic idle();
    iaen = 0; iden = 0; idata = 8'h00; iload_req = 0;
    ild_valid = 0; ild_data = 8'h00; ild_last = 0;
  endtask

  // Advance the model from the current inputs, then cross one rising edge.
  // Outputs are settled 1 time unit after the edge.
  task automatic tick();
    bit done_n;
    done_n = 1'b0;
    if (!m_load) begin
      if (iden) m_mem[m_addr] = idata;
      if (iaen) m_addr = idata[3:0];
      if (iload_req) begin
        m_load  = 1'b1;
        m_count = 0;
      end
    end else if (ild_valid) begin
      m_mem[m_count] = ild_data;
      m_count++;
      if (ild_last || m_count == 16) begin
        m_load = 1'b0;
        done_n = 1'b1;
      end
    end
    m_done = done_n;
    @(posedge iclk);
    #1;
  endtask

  task automatic read_word(input logic [3:0] addr, output logic [7:0] data);
    idle();
    iaen  = 1;
    idata = {4'h0, addr};
    tick();
    iaen = 0;
    data = odata;
  endtask

  task automatic test_reset();
    idle();
    irst_n = 0;
    model_reset();
    #12;
    n_checks++; if (odata !== 8'h00) $display("FAIL reset_odata: got %h want 00", odata); else n_pass++;
    n_checks++; if (old_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", old_ready); else n_pass++;
    n_checks++; if (oload_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", oload_busy); else n_pass++;
    n_checks++; if (oload_done !== 1'b0) $display("FAIL reset_done: got %b want 0", oload_done); else n_pass++;
    n_checks++; if (oload_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", oload_count); else n_pass++;
    @(negedge iclk);
    irst_n = 1;
  endtask

  task automatic test_cpu_rw();
    logic [7:0] rd;
    idle();
    iaen = 1; idata = 8'h05;
    tick();
    iaen = 0; iden = 1; idata = 8'hA3;
    tick();
    iden = 0;
    n_checks++; if (odata !== 8'hA3) $display("FAIL cpu_write_odata: got %h want a3", odata); else n_pass++;
    iaen = 1; idata = 8'h05;
    tick();
    iaen = 0;
    n_checks++; if (odata !== 8'hA3) $display("FAIL cpu_reread: got %h want a3", odata); else n_pass++;
    read_word(4'h6, rd);
    n_checks++; if (rd !== 8'h00) $display("FAIL cpu_unwritten: got %h want 00", rd); else n_pass++;
  endtask

  task automatic test_load3();
    logic [7:0] rd;
    logic [7:0] beats [3];
    beats[0] = 8'h11;
    beats[1] = 8'h22;
    beats[2] = 8'h33;
    idle();
    iload_req = 1;
    tick();
    iload_req = 0;
    n_checks++; if (old_ready !== 1'b1 || oload_busy !== 1'b1) $display("FAIL load3_enter: got ready=%b busy=%b want 1 1", old_ready, oload_busy); else n_pass++;
    n_checks++; if (oload_count !== 5'd0) $display("FAIL load3_count_clear: got %0d want 0", oload_count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      ild_valid = 1; ild_data = beats[i]; ild_last = (i == 2);
      tick();
      if (i < 2) begin
        n_checks++; if (oload_done !== 1'b0) $display("FAIL load3_early_done: beat %0d got %b want 0", i, oload_done); else n_pass++;
      end
    end
    idle();
    n_checks++; if (oload_done !== 1'b1) $display("FAIL load3_done: got %b want 1", oload_done); else n_pass++;
    n_checks++; if (oload_count !== 5'd3) $display("FAIL load3_count: got %0d want 3", oload_count); else n_pass++;
    n_checks++; if (old_ready !== 1'b0) $display("FAIL load3_ready_after: got %b want 0", old_ready); else n_pass++;
    tick();
    n_checks++; if (oload_done !== 1'b0) $display("FAIL load3_done_pulse: got %b want 0", oload_done); else n_pass++;
    n_checks++; if (oload_count !== 5'd3) $display("FAIL load3_count_hold: got %0d want 3", oload_count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      read_word(4'(i), rd);
      n_checks++; if (rd !== beats[i]) $display("FAIL load3_mem%0d: got %h want %h", i, rd, beats[i]); else n_pass++;
    end
  endtask

  task automatic test_full_load();
    logic [7:0] rd;
    logic [7:0] first;
    idle();
    iload_req = 1;
    tick();
    iload_req = 0;
    first = 8'h00;
    for (int i = 0; i < 16; i++) begin
      ild_valid = 1; ild_last = 0; ild_data = 8'($urandom_range(1, 255));
      if (i == 0) first = ild_data;
      tick();
    end
    n_checks++; if (oload_done !== 1'b1) $display("FAIL full_done: got %b want 1", oload_done); else n_pass++;
    n_checks++; if (oload_count !== 5'd16) $display("FAIL full_count: got %0d want 16", oload_count); else n_pass++;
    n_checks++; if (old_ready !== 1'b0 || oload_busy !== 1'b0) $display("FAIL full_exit: got ready=%b busy=%b want 0 0", old_ready, oload_busy); else n_pass++;
    // A 17th beat arrives after the FSM is back in RUN, so it must be dropped.
    ild_valid = 1; ild_data = ~first;
    tick();
    n_checks++; if (oload_count !== 5'd16) $display("FAIL full_extra_count: got %0d want 16", oload_count); else n_pass++;
    read_word(4'h0, rd);
    n_checks++; if (rd !== first) $display("FAIL full_mem0: got %h want %h", rd, first); else n_pass++;
    for (int i = 1; i < 16; i++) begin
      read_word(4'(i), rd);
      n_checks++; if (rd !== m_mem[i]) $display("FAIL full_mem%0d: got %h want %h", i, rd, m_mem[i]); else n_pass++;
    end
  endtask

  task automatic test_load_ignore();
    logic [7:0] rd;
    logic [7:0] keep2;
    read_word(4'h2, keep2);
    iload_req = 1;
    tick();
    // While loading, CPU writes, address latches and repeated requests must all be ignored.
    iload_req = 1; iden = 1; iaen = 1; idata = 8'hFF;
    tick();
    n_checks++; if (oload_count !== 5'd0) $display("FAIL ign_gap_count: got %0d want 0", oload_count); else n_pass++;
    n_checks++; if (odata !== keep2) $display("FAIL ign_cpu_addr: got %h want %h", odata, keep2); else n_pass++;
    iload_req = 0; iden = 0; iaen = 0;
    ild_valid = 1; ild_data = 8'h5C; ild_last = 1;
    tick();
    idle();
    n_checks++; if (oload_count !== 5'd1 || oload_done !== 1'b1) $display("FAIL ign_one_beat: got count=%0d done=%b want 1 1", oload_count, oload_done); else n_pass++;
    n_checks++; if (odata !== keep2) $display("FAIL ign_mem2: got %h want %h", odata, keep2); else n_pass++;
    read_word(4'h0, rd);
    n_checks++; if (rd !== 8'h5C) $display("FAIL ign_mem0: got %h want 5c", rd); else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [7:0] rd;
    read_word(4'h3, rd);
    iaen = 1; iden = 1; idata = 8'h07;
    tick();
    idle();
    n_checks++; if (odata !== m_mem[7]) $display("FAIL same_addr7: got %h want %h", odata, m_mem[7]); else n_pass++;
    read_word(4'h3, rd);
    n_checks++; if (rd !== 8'h07) $display("FAIL same_mem3: got %h want 07", rd); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] rd;
    bit         saw_done;
    idle();
    iload_req = 1;
    tick();
    iload_req = 0;
    for (int i = 0; i < 2; i++) begin
      ild_valid = 1; ild_data = 8'hC0 + 8'(i);
      tick();
    end
    #2;
    irst_n = 0;
    model_reset();
    #1;
    n_checks++; if (odata !== 8'h00 || old_ready !== 1'b0 || oload_busy !== 1'b0) $display("FAIL midrst_out: got odata=%h ready=%b busy=%b want 00 0 0", odata, old_ready, oload_busy); else n_pass++;
    n_checks++; if (oload_done !== 1'b0 || oload_count !== 5'd0) $display("FAIL midrst_ld: got done=%b count=%0d want 0 0", oload_done, oload_count); else n_pass++;
    idle();
    @(negedge iclk);
    irst_n = 1;
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (oload_done) saw_done = 1;
    end
    n_checks++; if (saw_done) $display("FAIL midrst_no_done: got pulse want none"); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      read_word(4'(i), rd);
      n_checks++; if (rd !== 8'h00) $display("FAIL midrst_mem%0d: got %h want 00", i, rd); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      iaen      = ($urandom_range(0, 3) == 0);
      iden      = ($urandom_range(0, 2) == 0);
      idata     = 8'($urandom);
      iload_req = ($urandom_range(0, 19) == 0);
      ild_valid = ($urandom_range(0, 1) == 1);
      ild_data  = 8'($urandom);
      ild_last  = ($urandom_range(0, 9) == 0);
      tick();
      n_checks++; if (odata !== m_mem[m_addr]) $display("FAIL rnd_odata c%0d: got %h want %h", c, odata, m_mem[m_addr]); else n_pass++;
      n_checks++; if (old_ready !== m_load || oload_busy !== m_load) $display("FAIL rnd_state c%0d: got ready=%b busy=%b want %b", c, old_ready, oload_busy, m_load); else n_pass++;
      n_checks++; if (oload_done !== m_done) $display("FAIL rnd_done c%0d: got %b want %b", c, oload_done, m_done); else n_pass++;
      n_checks++; if (oload_count !== 5'(m_count)) $display("FAIL rnd_count c%0d: got %0d want %0d", c, oload_count, m_count); else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_load3();
    test_full_load();
    test_load_ignore();
    test_same_cycle();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 pDATA_WIDTH, default 8: word width of the memory, CPU bus and loader data (cpu_pkg value).
REQ-002 pADDR_WIDTH, default 4: address width; depth pMEM_DEPTH = 2**pADDR_WIDTH; pADDR_WIDTH <= pDATA_WIDTH SHALL hold (elaboration error otherwise).
REQ-003 pREAD_LATENCY, default 0: 0 = combinational read, 1 = registered read; other values SHALL be an elaboration error.
REQ-004 iclk  in  1  single clock, all state on rising edge.
REQ-005 irst_n  in  1  asynchronous, active-low reset.
REQ-006 iaen  in  1  CPU address-latch enable, low pADDR_WIDTH bits of idata.
REQ-007 iden  in  1  CPU write enable: idata -> mem[CPU address].
REQ-008 idata  in  pDATA_WIDTH  CPU bus data.
REQ-009 odata  out  pDATA_WIDTH  read data, mem[CPU address].
REQ-010 iload_req  in  1  request to enter program-load mode.
REQ-011 ild_valid  in  1  loader beat valid.
REQ-012 ild_data  in  pDATA_WIDTH  loader beat data.
REQ-013 ild_last  in  1  marks final loader beat, qualified by ild_valid.
REQ-014 old_ready  out  1  loader may transfer this cycle.
REQ-015 oload_busy  out  1  high while in LOAD state.
REQ-016 oload_done  out  1  one-cycle pulse at end of load.
REQ-017 oload_count  out  pADDR_WIDTH+1  words written by the current or most recent load.

Function
REQ-018 State machine SHALL have two states, RUN and LOAD; reset state RUN.
REQ-019 RUN -> LOAD at the edge where iload_req=1; load pointer and oload_count SHALL clear to 0 at that edge.
REQ-020 In LOAD, iload_req SHALL be ignored.
REQ-021 old_ready SHALL equal (state==LOAD), combinational from state only.
REQ-022 Beat accepted when ild_valid && old_ready: mem[load pointer] <= ild_data, pointer +1, oload_count +1.
REQ-023 LOAD -> RUN at the edge of an accepted beat with ild_last=1 OR with pointer = pMEM_DEPTH-1; pointer never wraps.
REQ-024 oload_done SHALL be 1 for exactly the cycle following the terminating accepted beat, 0 otherwise.
REQ-025 oload_count SHALL hold its final value in RUN until the next load starts; full load gives pMEM_DEPTH.
REQ-026 ild_valid with old_ready=0 SHALL write nothing and change no state.
REQ-027 In RUN, iaen=1 SHALL latch CPU address at the edge; iden=1 SHALL write idata to mem[CPU address].
REQ-028 iaen and iden in the same RUN cycle: write SHALL use the address held before the edge; address updates at the same edge.
REQ-029 In LOAD, iaen and iden SHALL be ignored; CPU address register holds.
REQ-030 odata SHALL always reflect mem[CPU address] in both states, including words just loaded.
REQ-031 pREAD_LATENCY=0: odata updates in the same cycle as address/memory change; pREAD_LATENCY=1: odata is mem[CPU address] registered, valid one cycle later.
REQ-032 A write and a read of the same address in one cycle: odata shows the old word until the edge, the new word after (plus one cycle when pREAD_LATENCY=1).

Reset
REQ-033 irst_n=0 SHALL asynchronously clear all memory words, CPU address, load pointer, oload_count, registered odata to 0 and force state RUN.
REQ-034 During reset: odata=0, old_ready=0, oload_busy=0, oload_done=0, oload_count=0.
REQ-035 Reset asserted mid-load SHALL abort the load; no oload_done pulse; memory all 0 after release.
REQ-036 First edge after reset release SHALL be able to accept iaen/iden/iload_req.

Verification
REQ-037 Defaults: iaen with idata=0x05, next cycle iden with idata=0xA3, then iaen 0x05 -> odata=0xA3 (latency 0 same cycle, latency 1 one cycle later).
REQ-038 iload_req, beats 0x11,0x22,0x33 with ild_last on 3rd -> mem[0..2]=11,22,33, oload_done single pulse, oload_count=3, old_ready=0 after.
REQ-039 Load 16 beats, ild_last never set -> returns to RUN after beat 16, oload_count=16, 17th valid beat not written (mem[0] unchanged).
REQ-040 In LOAD assert iden with idata=0xFF at CPU address 2 -> mem[2] unchanged; ild_valid gaps -> no writes, pointer holds.
REQ-041 Same-cycle iaen(idata=0x07) and iden with address previously 0x03 -> mem[3]=0x07, address becomes 7.
REQ-042 irst_n pulsed low after 2 load beats -> all outputs 0, state RUN, mem[0],mem[1]=0, no oload_done.
